// File: rtl/uart_pkg.sv
// Shared constants and entry type for the UART receive FIFO.
// UART_RX_FIFO_BREAK_TAG_EN adds a break tag bit to every stored entry.
package uart_pkg;

   localparam int unsigned UART_PAYLOAD_WIDTH = 8;
   localparam int unsigned UART_FIFO_DEPTH    = 16;
   localparam int unsigned UART_FIFO_AFULL    = 12;

`ifdef UART_RX_FIFO_BREAK_TAG_EN
   localparam int unsigned UART_BREAK_TAG_W = 1;

   typedef struct packed {
      logic                          brk;
      logic [UART_PAYLOAD_WIDTH-1:0] data;
   } uart_fifo_entry_t;
`else
   localparam int unsigned UART_BREAK_TAG_W = 0;

   typedef struct packed {
      logic [UART_PAYLOAD_WIDTH-1:0] data;
   } uart_fifo_entry_t;
`endif

   function automatic int unsigned uart_entry_width(input int unsigned payload_w);
      return payload_w + UART_BREAK_TAG_W;
   endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port.
// Array contents are never reset; only the read register is.
module uart_fifo_mem #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read-before-write: a same-address write in this cycle is not visible yet.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: pointers, level, flags and sticky overrun.
// UART_RX_FIFO_BREAK_TAG_EN stores the break flag per entry and adds the rd_break output.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned PAYLOAD_WIDTH = UART_PAYLOAD_WIDTH,
   parameter int unsigned DEPTH         = UART_FIFO_DEPTH,
   parameter int unsigned AFULL_THRESH  = UART_FIFO_AFULL
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       uart_rx_valid,
   input  logic                       uart_rx_break,
   input  logic [PAYLOAD_WIDTH-1:0]   uart_rx_data,
   input  logic                       rd_en,
   output logic [PAYLOAD_WIDTH-1:0]   rd_data,
   output logic                       rd_valid,
   output logic                       fifo_empty,
   output logic                       fifo_full,
   output logic                       almost_full,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       overrun,
   input  logic                       overrun_clr
`ifdef UART_RX_FIFO_BREAK_TAG_EN
   ,
   output logic                       rd_break
`endif
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned LVL_W   = PTR_W + 1;
   localparam int unsigned ENTRY_W = uart_entry_width(PAYLOAD_WIDTH);

   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]   level_q, level_d;
   logic               empty_q, full_q, afull_q, overrun_q, rd_valid_q;
   logic               accept, push, pop, drop;
   logic [ENTRY_W-1:0] wr_entry, rd_entry;

`ifdef UART_RX_FIFO_BREAK_TAG_EN
   assign accept   = uart_rx_valid;
   assign wr_entry = {uart_rx_break, uart_rx_data};
   assign rd_data  = rd_entry[PAYLOAD_WIDTH-1:0];
   assign rd_break = rd_entry[PAYLOAD_WIDTH];
`else
   // Without the tag there is nowhere to mark a break, so it is discarded outright.
   assign accept   = uart_rx_valid && !uart_rx_break;
   assign wr_entry = uart_rx_data;
   assign rd_data  = rd_entry;
`endif

   always_comb begin
      pop     = rd_en && !empty_q;
      push    = accept && (!full_q || pop);
      drop    = accept && full_q && !pop;
      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
         level_d = level_q - LVL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         afull_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         level_q    <= level_d;
         // Flags follow level_d so they line up with fifo_level every cycle.
         empty_q    <= (level_d == '0);
         full_q     <= (level_d == LVL_W'(DEPTH));
         afull_q    <= (level_d >= LVL_W'(AFULL_THRESH));
         rd_valid_q <= pop;
         if (drop) begin
            overrun_q <= 1'b1;
         end else if (overrun_clr) begin
            overrun_q <= 1'b0;
         end
      end
   end

   uart_fifo_mem #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (wr_entry),
      .re    (pop),
      .raddr (rd_ptr_q),
      .rdata (rd_entry)
   );

   assign rd_valid    = rd_valid_q;
   assign fifo_empty  = empty_q;
   assign fifo_full   = full_q;
   assign almost_full = afull_q;
   assign fifo_level  = level_q;
   assign overrun     = overrun_q;

endmodule
